// File: rtl/minmax_tracker.sv
// Streaming frame min/max tracker: records the extreme values, their beat indices
// and the beat count of each frame, then holds the result until it is consumed.
module minmax_tracker #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             signed_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  output logic [WIDTH-1:0] min_o,
  output logic [WIDTH-1:0] max_o,
  output logic [CNT_W-1:0] min_idx_o,
  output logic [CNT_W-1:0] max_idx_o,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o,
  output logic             result_valid_o,
  input  logic             result_ready_i
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             live_q;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] min_q, min_d, max_q, max_d;
  logic [CNT_W-1:0] min_idx_q, min_idx_d, max_idx_q, max_idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             accept, lt_min, gt_max;

  // live_q keeps ready_o low while in reset and for the first edge after release
  always_comb begin
    ready_o        = live_q && (state_q != HOLD);
    result_valid_o = (state_q == HOLD);
    accept         = valid_i && ready_o;
    if (sign_q) begin
      lt_min = $signed(data_i) < $signed(min_q);
      gt_max = $signed(data_i) > $signed(max_q);
    end else begin
      lt_min = data_i < min_q;
      gt_max = data_i > max_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    min_d     = min_q;
    max_d     = max_q;
    min_idx_d = min_idx_q;
    max_idx_d = max_idx_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d    = signed_i;
          min_d     = data_i;
          max_d     = data_i;
          min_idx_d = '0;
          max_idx_d = '0;
          count_d   = CNT_W'(1);
          ovf_d     = 1'b0;
          state_d   = last_i ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (lt_min) begin
            min_d     = data_i;
            min_idx_d = count_q;
          end
          if (gt_max) begin
            max_d     = data_i;
            max_idx_d = count_q;
          end
          // Once saturated, count_q doubles as the recorded index of later beats
          if (count_q == CNT_MAX) ovf_d = 1'b1;
          else                    count_d = count_q + CNT_W'(1);
          if (last_i) state_d = HOLD;
        end
      end
      HOLD: begin
        if (result_ready_i) begin
          state_d = IDLE;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      live_q    <= 1'b0;
      sign_q    <= 1'b0;
      min_q     <= '0;
      max_q     <= '0;
      min_idx_q <= '0;
      max_idx_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      live_q    <= 1'b1;
      sign_q    <= sign_d;
      min_q     <= min_d;
      max_q     <= max_d;
      min_idx_q <= min_idx_d;
      max_idx_q <= max_idx_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  assign min_o     = min_q;
  assign max_o     = max_q;
  assign min_idx_o = min_idx_q;
  assign max_idx_o = max_idx_q;
  assign count_o   = count_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_minmax_tracker.sv
// Directed bench for minmax_tracker: default-width instance plus a CNT_W=2
// instance for saturation, with expected frame results queued as a scoreboard.
module tb_minmax_tracker;

  typedef struct packed {
    logic [7:0] mn;
    logic [7:0] mx;
    logic [7:0] mn_idx;
    logic [7:0] mx_idx;
    logic [7:0] cnt;
    logic       ovf;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       sgn = 1'b0, vld = 1'b0, lst = 1'b0, rrdy = 1'b0;
  logic [7:0] dat = '0;
  logic       rdy, rv, ovf;
  logic [7:0] mn, mx, mn_idx, mx_idx, cnt;

  logic       o_sgn = 1'b0, o_vld = 1'b0, o_lst = 1'b0, o_rrdy = 1'b0;
  logic [7:0] o_dat = '0;
  logic       o_rdy, o_rv, o_ovf;
  logic [7:0] o_mn, o_mx;
  logic [1:0] o_mn_idx, o_mx_idx, o_cnt;

  res_t obs1, obs2;
  res_t sb[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  minmax_tracker #(.WIDTH(8), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .signed_i(sgn), .valid_i(vld), .ready_o(rdy),
    .data_i(dat), .last_i(lst), .min_o(mn), .max_o(mx), .min_idx_o(mn_idx),
    .max_idx_o(mx_idx), .count_o(cnt), .ovf_o(ovf), .result_valid_o(rv),
    .result_ready_i(rrdy)
  );

  minmax_tracker #(.WIDTH(8), .CNT_W(2)) dut_ovf (
    .clk_i(clk), .rst_ni(rst_n), .signed_i(o_sgn), .valid_i(o_vld), .ready_o(o_rdy),
    .data_i(o_dat), .last_i(o_lst), .min_o(o_mn), .max_o(o_mx), .min_idx_o(o_mn_idx),
    .max_idx_o(o_mx_idx), .count_o(o_cnt), .ovf_o(o_ovf), .result_valid_o(o_rv),
    .result_ready_i(o_rrdy)
  );

  always_comb begin
    obs1 = '{mn: mn, mx: mx, mn_idx: mn_idx, mx_idx: mx_idx, cnt: cnt, ovf: ovf};
    obs2 = '{mn: o_mn, mx: o_mx, mn_idx: {6'b0, o_mn_idx}, mx_idx: {6'b0, o_mx_idx},
             cnt: {6'b0, o_cnt}, ovf: o_ovf};
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic push(input logic [7:0] emn, input logic [7:0] emx, input logic [7:0] emi,
                      input logic [7:0] exi, input logic [7:0] ec, input logic eo);
    sb.push_back('{mn: emn, mx: emx, mn_idx: emi, mx_idx: exi, cnt: ec, ovf: eo});
  endtask

  // Called at the negedge right after the last beat's accepting edge
  task automatic check_res(input string tag, input res_t o, input logic valid);
    res_t e;
    chk({tag, ".rvalid"}, {31'b0, valid}, 32'd1);
    if (sb.size() == 0) begin
      chk({tag, ".sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, ".min"},     {24'b0, o.mn},     {24'b0, e.mn});
      chk({tag, ".max"},     {24'b0, o.mx},     {24'b0, e.mx});
      chk({tag, ".min_idx"}, {24'b0, o.mn_idx}, {24'b0, e.mn_idx});
      chk({tag, ".max_idx"}, {24'b0, o.mx_idx}, {24'b0, e.mx_idx});
      chk({tag, ".count"},   {24'b0, o.cnt},    {24'b0, e.cnt});
      chk({tag, ".ovf"},     {31'b0, o.ovf},    {31'b0, e.ovf});
    end
  endtask

  task automatic beat(input int unsigned which, input logic [7:0] d, input logic l, input logic s);
    if (which == 0) begin
      vld = 1'b1; dat = d; lst = l; sgn = s;
      chk("beat.ready", {31'b0, rdy}, 32'd1);
    end else begin
      o_vld = 1'b1; o_dat = d; o_lst = l; o_sgn = s;
      chk("obeat.ready", {31'b0, o_rdy}, 32'd1);
    end
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
    o_vld = 1'b0;
  endtask

  task automatic handshake(input int unsigned which);
    if (which == 0) rrdy = 1'b1; else o_rrdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rrdy = 1'b0;
    o_rrdy = 1'b0;
    if (which == 0) begin
      chk("hs.rvalid_low", {31'b0, rv}, 32'd0);
      chk("hs.ready_back", {31'b0, rdy}, 32'd1);
    end else begin
      chk("ohs.rvalid_low", {31'b0, o_rv}, 32'd0);
      chk("ohs.ovf_cleared", {31'b0, o_ovf}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst.ready", {31'b0, rdy}, 32'd0);
    chk("rst.rvalid", {31'b0, rv}, 32'd0);
    chk("rst.ovf", {31'b0, ovf}, 32'd0);
    chk("rst.min", {24'b0, mn}, 32'd0);
    chk("rst.count", {24'b0, cnt}, 32'd0);
    rst_n = 1'b1;
    chk("rst_rel.ready_not_yet", {31'b0, rdy}, 32'd0);
    @(negedge clk);
    chk("rst_rel.ready", {31'b0, rdy}, 32'd1);

    // Signed frame; signed_i toggled mid-frame must be ignored
    push(8'hD3, 8'd56, 8'd3, 8'd1, 8'd4, 1'b0);
    beat(0, 8'd45, 1'b0, 1'b1);
    beat(0, 8'd56, 1'b0, 1'b0);
    beat(0, 8'd36, 1'b0, 1'b0);
    beat(0, 8'hD3, 1'b1, 1'b0);
    check_res("signed", obs1, rv);
    chk("signed.ready_low", {31'b0, rdy}, 32'd0);
    handshake(0);

    // Unsigned frame with the same beats
    push(8'd36, 8'hD3, 8'd2, 8'd3, 8'd4, 1'b0);
    beat(0, 8'd45, 1'b0, 1'b0);
    beat(0, 8'd56, 1'b0, 1'b1);
    beat(0, 8'd36, 1'b0, 1'b1);
    beat(0, 8'hD3, 1'b1, 1'b1);
    check_res("unsigned", obs1, rv);
    handshake(0);

    // Single-beat frame
    push(8'd45, 8'd45, 8'd0, 8'd0, 8'd1, 1'b0);
    beat(0, 8'd45, 1'b1, 1'b0);
    check_res("single", obs1, rv);
    handshake(0);

    // Ties with an idle gap, then backpressure with valid_i held high
    push(8'd7, 8'd7, 8'd0, 8'd0, 8'd3, 1'b0);
    beat(0, 8'd7, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("gap.count", {24'b0, cnt}, 32'd1);
    beat(0, 8'd7, 1'b0, 1'b0);
    beat(0, 8'd7, 1'b1, 1'b0);
    check_res("ties", obs1, rv);
    vld = 1'b1; dat = 8'd99; lst = 1'b1; sgn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp.ready", {31'b0, rdy}, 32'd0);
      chk("bp.rvalid", {31'b0, rv}, 32'd1);
      chk("bp.min", {24'b0, mn}, 32'd7);
      chk("bp.count", {24'b0, cnt}, 32'd3);
      chk("bp.max_idx", {24'b0, mx_idx}, 32'd0);
    end
    rrdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rrdy = 1'b0;
    chk("bp_hs.rvalid_low", {31'b0, rv}, 32'd0);
    chk("bp_hs.ready", {31'b0, rdy}, 32'd1);
    chk("bp_hs.no_accept", {24'b0, cnt}, 32'd3);
    push(8'd99, 8'd99, 8'd0, 8'd0, 8'd1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0; lst = 1'b0;
    check_res("after_bp", obs1, rv);
    handshake(0);

    // Reset mid-frame discards the partial result asynchronously
    beat(0, 8'd100, 1'b0, 1'b0);
    beat(0, 8'd200, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst.min", {24'b0, mn}, 32'd0);
    chk("midrst.max", {24'b0, mx}, 32'd0);
    chk("midrst.count", {24'b0, cnt}, 32'd0);
    chk("midrst.ready", {31'b0, rdy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(8'd5, 8'd9, 8'd1, 8'd0, 8'd2, 1'b0);
    beat(0, 8'd9, 1'b0, 1'b0);
    beat(0, 8'd5, 1'b1, 1'b0);
    check_res("post_rst", obs1, rv);
    handshake(0);

    // Saturation on the CNT_W=2 instance
    push(8'd0, 8'd4, 8'd3, 8'd3, 8'd3, 1'b1);
    beat(1, 8'd1, 1'b0, 1'b0);
    beat(1, 8'd2, 1'b0, 1'b0);
    beat(1, 8'd3, 1'b0, 1'b0);
    chk("ovf.not_yet", {31'b0, o_ovf}, 32'd0);
    beat(1, 8'd4, 1'b0, 1'b0);
    beat(1, 8'd0, 1'b1, 1'b0);
    check_res("ovf", obs2, o_rv);
    handshake(1);

    chk("sb.drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
